// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the core's load/store path.
// One request at a time over valid/ready, optional wait states, byte-masked
// stores, and sign/zero-extended loads. The response is held until accepted.
// Optional feature macro: DMEM_RESP_ALIGN_CHECK_EN. When it is defined,
// misaligned or inconsistent accesses are rejected with resp_err. When it is
// undefined, resp_err stays 0 and no alignment checking is done.
module dmem_resp #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [3:0]      req_amp,
    input  logic [1:0]      req_lwhb,
    input  logic            req_lunsigned,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    typedef struct packed {
        logic            we;
        logic [AW+1:0]   addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      amp;
        logic [1:0]      lwhb;
        logic            lunsigned;
    } req_t;

    state_t          state_q, state_d;
    req_t            req_q, req_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q;
    logic            resp_valid_q, resp_valid_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic            mem_we_c;
    logic            err_c;
    logic [AW-1:0]   idx_c;
    logic [XLEN-1:0] word_c;
    logic [15:0]     half_c;
    logic [7:0]      byte_c;
    logic [XLEN-1:0] load_c;
    logic            unused_addr_hi;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    // Address bits above the array are intentionally ignored
    assign unused_addr_hi = ^req_addr[XLEN-1:AW+2];

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // State register; ready is registered from the next state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
            S_WAIT:   if (cnt_q <= CW'(1)) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   if (resp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next values and memory write strobe per state
    always_comb begin
        req_d        = req_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_d.we        = req_we;
                    req_d.addr      = req_addr[AW+1:0];
                    req_d.wdata     = req_wdata;
                    req_d.amp       = req_amp;
                    req_d.lwhb      = req_lwhb;
                    req_d.lunsigned = req_lunsigned;
                    cnt_d           = CW'(WAIT_CYCLES);
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            S_ACCESS: begin
                resp_valid_d = 1'b1;
                resp_err_d   = err_c;
                resp_rdata_d = (req_q.we || err_c) ? '0 : load_c;
                mem_we_c     = req_q.we && !err_c;
            end
            S_RESP: begin
                if (resp_ready) resp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Response and wait-counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Request holding register
    always_ff @(posedge clk) begin
        req_q <= req_d;
    end

    assign idx_c = req_q.addr[AW+1:2];

    // Byte-masked store; suppressed by a reset in the same cycle
    always_ff @(posedge clk) begin
        if (reset && mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (req_q.amp[b]) mem_q[idx_c][8*b +: 8] <= req_q.wdata[8*b +: 8];
            end
        end
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        word_c = mem_q[idx_c];
        half_c = req_q.addr[1] ? word_c[31:16] : word_c[15:0];
        byte_c = word_c[{req_q.addr[1:0], 3'b000} +: 8];
        case (req_q.lwhb)
            2'b10:   load_c = req_q.lunsigned ? {{(XLEN-16){1'b0}}, half_c}
                                              : {{(XLEN-16){half_c[15]}}, half_c};
            2'b11:   load_c = req_q.lunsigned ? {{(XLEN-8){1'b0}}, byte_c}
                                              : {{(XLEN-8){byte_c[7]}}, byte_c};
            default: load_c = word_c;
        endcase
    end

`ifdef DMEM_RESP_ALIGN_CHECK_EN
    // Reject misaligned loads and stores whose byte enables disagree with the address
    always_comb begin
        err_c = 1'b0;
        if (req_q.we) begin
            case (req_q.amp)
                4'b1111: err_c = (req_q.addr[1:0] != 2'b00);
                4'b0011: err_c = req_q.addr[1];
                4'b1100: err_c = !req_q.addr[1];
                4'b0001, 4'b0010, 4'b0100, 4'b1000:
                         err_c = (req_q.amp != (4'b0001 << req_q.addr[1:0]));
                default: err_c = 1'b1;
            endcase
        end else begin
            case (req_q.lwhb)
                2'b10:   err_c = req_q.addr[0];
                2'b11:   err_c = 1'b0;
                default: err_c = (req_q.addr[1:0] != 2'b00);
            endcase
        end
    end
`else
    assign err_c = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: a driver pushes expected responses computed
// by a word-array reference model; a monitor pops and compares on resp_valid.
module tb_dmem_resp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned WAIT  = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [XLEN-1:0] req_addr = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic [3:0]      req_amp = '0;
    logic [1:0]      req_lwhb = '0;
    logic            req_lunsigned = 1'b0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    always #5 clk = ~clk;

    dmem_resp #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_amp(req_amp),
        .req_lwhb(req_lwhb), .req_lunsigned(req_lunsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] acc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned cyc = 0;
    int unsigned hold_low = 0;
    logic [31:0] mdl [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    endtask

    // Reference: which accesses are rejected when alignment checking is built in
    function automatic logic model_err(input logic we, input logic [1:0] a,
                                       input logic [3:0] amp, input logic [1:0] sz);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
        logic [3:0] lane;
        lane = 4'b0001 << a;
        if (!we) begin
            if (sz == 2'b10) return a[0];
            if (sz == 2'b11) return 1'b0;
            return a != 2'b00;
        end
        if (amp == 4'b1111) return a != 2'b00;
        if (amp == 4'b0011) return a[1] != 1'b0;
        if (amp == 4'b1100) return a[1] != 1'b1;
        if (amp == 4'b0001 || amp == 4'b0010 || amp == 4'b0100 || amp == 4'b1000)
            return amp != lane;
        return 1'b1;
`else
        return 1'b0 & we & a[0] & amp[0] & sz[0];
`endif
    endfunction

    // Reference: apply the access to the word array and produce the response
    task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] amp, input logic [1:0] sz, input logic lu,
                                output exp_t e);
        int unsigned idx;
        int unsigned a;
        logic [31:0] w;
        logic [31:0] v;
        idx = int'(addr[7:2]);
        a   = int'(addr[1:0]);
        e.err   = model_err(we, addr[1:0], amp, sz);
        e.rdata = 32'h0;
        e.acc   = cyc;
        if (we) begin
            if (!e.err)
                for (int b = 0; b < 4; b++)
                    if (amp[b]) begin
                        w = mdl[idx] & ~(32'hFF << (8*b));
                        mdl[idx] = w | (wd & (32'hFF << (8*b)));
                    end
        end else if (!e.err) begin
            w = mdl[idx];
            if (sz == 2'b10) begin
                v = (w >> (a >= 2 ? 16 : 0)) & 32'h0000FFFF;
                if (!lu && v[15]) v = v | 32'hFFFF0000;
            end else if (sz == 2'b11) begin
                v = (w >> (8*a)) & 32'h000000FF;
                if (!lu && v[7]) v = v | 32'hFFFFFF00;
            end else begin
                v = w;
            end
            e.rdata = v;
        end
    endtask

    // Issue one request; abort=1 asserts reset while the request is in WAIT
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] amp, input logic [1:0] sz, input logic lu,
                         input bit abort);
        exp_t e;
        int guard;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wd; req_amp = amp;
        req_lwhb = sz; req_lunsigned = lu; req_valid = 1'b1;
        guard = 0;
        while (!req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                n_chk++;
                $display("FAIL accept_timeout: req_ready stuck at %0b expected 1", req_ready);
                req_valid = 1'b0;
                return;
            end
        end
        if (!abort) begin
            model_access(we, addr, wd, amp, sz, lu, e);
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (abort) begin
            rst_n = 1'b0;
            @(negedge clk);
            chk("abort_req_ready", 32'(req_ready), 32'd1);
            chk("abort_resp_valid", 32'(resp_valid), 32'd0);
            rst_n = 1'b1;
        end
    endtask

    exp_t cur;
    bit   active = 1'b0;

    // Response-ready driver followed by the scoreboard monitor
    always @(negedge clk) begin
        if (hold_low > 0) begin
            resp_ready = 1'b0;
            hold_low   = hold_low - 1;
        end else begin
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        if (rst_n && resp_valid) begin
            if (!active) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_resp: rdata %h with empty scoreboard", resp_rdata);
                end else begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    chk("latency", 32'(cyc - cur.acc), 32'(2 + WAIT));
                    chk("rdata", resp_rdata, cur.rdata);
                    chk("err", 32'(resp_err), 32'(cur.err));
                end
            end else begin
                chk("hold_rdata", resp_rdata, cur.rdata);
                chk("hold_err", 32'(resp_err), 32'(cur.err));
            end
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (resp_ready) active = 1'b0;
        end
    end

    initial begin
        logic [31:0] ra;
        logic [3:0]  amp;
        logic        we;
        int          guard;

        repeat (2) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;

        // Give every word a known value
        for (int i = 0; i < int'(DEPTH); i++)
            issue(1'b1, 32'(i * 4), $urandom, 4'b1111, 2'b01, 1'b0, 1'b0);

        // Directed loads and stores
        issue(1'b1, 32'h80000010, 32'hDEADBEEF, 4'b1111, 2'b01, 1'b0, 1'b0);
        issue(1'b0, 32'h80000010, 32'h0,        4'b0000, 2'b01, 1'b0, 1'b0);
        issue(1'b1, 32'h00000010, 32'h00AA0000, 4'b0100, 2'b01, 1'b0, 1'b0);
        issue(1'b0, 32'h00000012, 32'h0,        4'b0000, 2'b11, 1'b0, 1'b0);
        issue(1'b0, 32'h00000012, 32'h0,        4'b0000, 2'b11, 1'b1, 1'b0);
        issue(1'b0, 32'h00000010, 32'h0,        4'b0000, 2'b01, 1'b0, 1'b0);
        issue(1'b0, 32'h00000012, 32'h0,        4'b0000, 2'b10, 1'b0, 1'b0);
        issue(1'b0, 32'h00000012, 32'h0,        4'b0000, 2'b10, 1'b1, 1'b0);
        issue(1'b0, 32'h00000010, 32'h0,        4'b0000, 2'b10, 1'b0, 1'b0);
        issue(1'b0, 32'h00000010, 32'h0,        4'b0000, 2'b00, 1'b0, 1'b0);

        // Core stalls the response for several cycles
        hold_low = 12;
        issue(1'b0, 32'h00000010, 32'h0, 4'b0000, 2'b01, 1'b0, 1'b0);

        // Store dropped by reset in WAIT, then read back prior contents
        issue(1'b1, 32'h00000020, 32'h11111111, 4'b1111, 2'b01, 1'b0, 1'b1);
        issue(1'b0, 32'h00000020, 32'h0,        4'b0000, 2'b01, 1'b0, 1'b0);

        // Misaligned word load and inconsistent half store
        issue(1'b0, 32'h00000013, 32'h0,        4'b0000, 2'b01, 1'b0, 1'b0);
        issue(1'b1, 32'h00000012, 32'h12345678, 4'b0011, 2'b01, 1'b0, 1'b0);
        issue(1'b0, 32'h00000010, 32'h0,        4'b0000, 2'b01, 1'b0, 1'b0);

        // Back-to-back read-after-write plus random traffic
        for (int n = 0; n < 250; n++) begin
            ra = $urandom;
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2: amp = 4'b1111;
                3, 4, 5: amp = ra[1] ? 4'b1100 : 4'b0011;
                6, 7, 8: amp = 4'b0001 << ra[1:0];
                default: amp = 4'($urandom_range(0, 15));
            endcase
            issue(we, ra, $urandom, amp, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
            if (we) issue(1'b0, ra & 32'hFFFFFFFC, 32'h0, 4'b0000, 2'b01, 1'b0, 1'b0);
        end

        guard = 0;
        while ((exp_q.size() != 0 || active) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder: the memory end of the core's load/store path.
- Accepts one request at a time over a valid/ready handshake. The store byte-enable pattern is already produced on the CPU side.
- Stores perform a byte-masked write. Loads read the word, then extract the byte or half and sign/zero-extend it.
- Wait-state counter adds programmable latency. Response is held until the core accepts it.

Parameters:
- XLEN, 32, data/address width.
- DEPTH_WORDS, 1024, number of 32-bit words in the internal array. Must be a power of 2.
- WAIT_CYCLES, 0, extra cycles between request accept and response valid (0..15).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset. reset==0 at a posedge resets the block.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept; high only in IDLE.
- req_we  input  1  1=store, 0=load.
- req_addr  input  XLEN  byte address. Word index = req_addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored.
- req_wdata  input  XLEN  store data, already lane-positioned.
- req_amp  input  4  store byte enables: 1111, 0011, 1100, 0001, 0010, 0100 or 1000.
- req_lwhb  input  2  load size: 01 word, 10 half, 11 byte. 00 is treated as word.
- req_lunsigned  input  1  1 = zero-extend loads (lbu/lhu).
- resp_valid  output  1  response present.
- resp_ready  input  1  core accepts response.
- resp_rdata  output  XLEN  extended load data; 0 for stores.
- resp_err  output  1  access rejected (see Optional Feature).

Behaviour:
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, wait counter 0, req_ready 1. Array contents are not reset.
- FSM IDLE: req_ready=1. On req_valid, capture all req_* fields into holding registers and load counter=WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else ACCESS.
- FSM WAIT: req_ready=0. Decrement counter each cycle; go to ACCESS when counter==1.
- FSM ACCESS: one cycle.
  - Store: write held wdata byte lanes where amp bit=1.
  - Load: read the addressed word and compute the extracted result into resp_rdata.
  - Set resp_valid=1 and go to RESP.
- FSM RESP: hold resp_valid, resp_rdata and resp_err stable. On resp_ready, clear resp_valid and go to IDLE.
- Latency: request accepted at edge N; resp_valid is visible after edge N+1+WAIT_CYCLES.
  - Next accept is possible the cycle after the response handshake.
  - Peak throughput is one access per 3+WAIT_CYCLES cycles.
- Load extraction, on word w with address a:
  - Word: w.
  - Half: a[1] ? w[31:16] : w[15:0].
  - Byte: lane selected by a[1:0].
  - Sign-extend from bit 15 or 7 unless lunsigned=1.
- Store committed with resp_err=1: no write occurs and resp_rdata=0.
- Load with resp_err=1: resp_rdata=0.
- req_valid while not IDLE: ignored. The request must be held by the core until req_ready.
- Reset in WAIT or ACCESS: state goes to IDLE and the pending store is dropped (array unchanged).
- Reset in RESP: response discarded.
- Read-after-write to the same word in back-to-back requests returns the new data.

Optional Feature:
- Macro: DMEM_RESP_ALIGN_CHECK_EN.
- Defined: resp_err=1 for any of the following:
  - word load with a[1:0]!=0;
  - half load with a[0]=1;
  - store with amp==0000;
  - store amp inconsistent with a[1:0] (word requires a[1:0]=00; half requires amp 0011 when a[1]=0 or 1100 when a[1]=1; byte requires the single bit matching a[1:0]).
- Not defined: resp_err tied 0 and no checking.
  - Misaligned word loads ignore a[1:0]; half loads ignore a[0].
  - Stores write whatever amp specifies.

Test Plan:
- Reset low 2 cycles, then high -> req_ready=1, resp_valid=0, resp_rdata=0. Store addr 0x80000010, wdata 0xDEADBEEF, amp 1111; then load word -> resp_rdata=0xDEADBEEF.
- Store amp 0100, wdata 0x00AA0000 at 0x10, then load byte at 0x12 -> 0xFFFFFFAA. Same with lunsigned=1 -> 0x000000AA. Load word -> 0xDEAABEEF.
- Load half at 0x12 with signed and unsigned -> 0xFFFFDEAA and 0x0000DEAA. Load half at 0x10 -> 0xFFFFBEEF.
- WAIT_CYCLES=3: accept at edge N -> resp_valid exactly after edge N+4. Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout.
- Assert reset during WAIT of a store of 0x11111111 to 0x20 -> IDLE next cycle; later load from 0x20 returns the prior contents.
- With DMEM_RESP_ALIGN_CHECK_EN, word load at 0x13 -> resp_err=1, resp_rdata=0. Store amp 0011 at 0x12 -> resp_err=1, memory unchanged. Without the macro, same load -> word at 0x10, resp_err=0.
